// File: rtl/sc_ifetch.sv
// Instruction fetch: holds PC, fetches over req/ack, presents inst until commit; IF_MISALIGN_TRAP_EN redirects misaligned jr to TRAP_VEC.
// Latency: one idle cycle after reset, then S_FETCH -> S_EXEC on the ack edge (best case 1 cycle).
// Backpressure: imem_req/imem_addr hold until imem_ack; inst/pc hold until commit.
module sc_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0080
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] ra,
  input  logic        commit,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        trap
);

  typedef enum logic [1:0] {
    S_RST   = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10
  } state_t;

  state_t      state;
  logic [31:0] npc;
  logic [31:0] br_off;
  logic [31:0] jr_tgt;
  logic        jr_trap;
  logic        trap_r;

  assign pc4       = pc + 32'd4;
  assign imem_addr = pc;
  assign trap      = trap_r;
  assign br_off    = {{14{inst[15]}}, inst[15:0], 2'b00};

`ifdef IF_MISALIGN_TRAP_EN
  assign jr_trap = (ra[1:0] != 2'b00);
  assign jr_tgt  = jr_trap ? TRAP_VEC : ra;
`else
  // Low address bits of a jr target are dropped so pc stays word-aligned.
  assign jr_trap = 1'b0;
  assign jr_tgt  = ra & 32'hFFFF_FFFC;
`endif

  always_comb begin
    npc = pc4;
    case (pcsource)
      2'b00:   npc = pc4;
      2'b01:   npc = pc4 + br_off;
      2'b10:   npc = jr_tgt;
      default: npc = {pc4[31:28], inst[25:0], 2'b00};
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= S_RST;
      pc         <= RESET_PC;
      inst       <= '0;
      inst_valid <= 1'b0;
      imem_req   <= 1'b0;
      trap_r     <= 1'b0;
    end else begin
      trap_r <= 1'b0;
      case (state)
        S_RST: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ack) begin
            inst       <= imem_rdata;
            inst_valid <= 1'b1;
            imem_req   <= 1'b0;
            state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (commit) begin
            pc         <= npc;
            inst_valid <= 1'b0;
            imem_req   <= 1'b1;
            trap_r     <= (pcsource == 2'b10) && jr_trap;
            state      <= S_FETCH;
          end
        end
        default: begin
          state      <= S_RST;
          inst_valid <= 1'b0;
          imem_req   <= 1'b0;
        end
      endcase
    end
  end

  // Both vectors must be word-aligned or the pc alignment invariant breaks.
  a_vec_aligned: assert property (@(posedge clock) disable iff (!resetn)
    (RESET_PC[1:0] == 2'b00) && (TRAP_VEC[1:0] == 2'b00));

endmodule

// File: tb/tb_sc_ifetch.sv
// Random + directed fetch/commit traffic; scoreboard queues checked by a negedge monitor.
module tb_sc_ifetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0080;

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] ra = '0;
  logic        commit = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] inst;
  logic        inst_valid;
  logic        trap;

  sc_ifetch #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clock(clock), .resetn(resetn), .pcsource(pcsource), .ra(ra), .commit(commit),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .pc(pc), .pc4(pc4), .inst(inst),
    .inst_valid(inst_valid), .trap(trap)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  logic [31:0] exp_addr_q[$];
  exp_t        exp_inst_q[$];
  int          trap_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] pc_model = RESET_PC;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference next-PC: returns {trap, npc}
  function automatic logic [32:0] ref_next(input logic [31:0] p, input logic [31:0] w,
                                           input logic [1:0] ps, input logic [31:0] r);
    logic [31:0] p4;
    logic [31:0] n;
    logic        t;
    int          off;
    p4  = p + 32'd4;
    t   = 1'b0;
    off = int'($signed(w[15:0]));
    case (ps)
      2'd0: n = p4;
      2'd1: n = p4 + 32'(off * 4);
      2'd2: begin
        if ((r % 32'd4) != 32'd0) begin
`ifdef IF_MISALIGN_TRAP_EN
          n = TRAP_VEC;
          t = 1'b1;
`else
          n = r - (r % 32'd4);
`endif
        end else begin
          n = r;
        end
      end
      default: n = (p4 & 32'hF000_0000) | (32'(w[25:0]) << 2);
    endcase
    return {t, n};
  endfunction

  // Monitor: pops the scoreboard on each new fetch / new instruction, checks holds
  logic        prev_req = 1'b0;
  logic        prev_iv = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] prev_inst = '0;
  logic [31:0] prev_pc = '0;

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (!resetn) begin
      prev_req = 1'b0;
      prev_iv  = 1'b0;
    end else begin
      logic exp_trap;
      exp_t e;
      exp_trap = (trap_q.size() > 0) && (trap_q[0] == cyc);
      if (exp_trap) void'(trap_q.pop_front());
      chk("trap", {31'd0, trap}, {31'd0, exp_trap});
      if (imem_req && !prev_req) begin
        if (exp_addr_q.size() == 0) begin
          chk("unexpected_fetch", imem_addr, 32'hxxxx_xxxx);
        end else begin
          chk("fetch_addr", imem_addr, exp_addr_q.pop_front());
        end
      end else if (imem_req && prev_req) begin
        chk("addr_hold", imem_addr, prev_addr);
        chk("iv_during_fetch", {31'd0, inst_valid}, 32'd0);
      end
      if (inst_valid && !prev_iv) begin
        if (exp_inst_q.size() == 0) begin
          chk("unexpected_inst", inst, 32'hxxxx_xxxx);
        end else begin
          e = exp_inst_q.pop_front();
          chk("inst", inst, e.word);
          chk("pc", pc, e.pc);
          chk("pc4", pc4, e.pc + 32'd4);
          chk("req_in_exec", {31'd0, imem_req}, 32'd0);
        end
      end else if (inst_valid && prev_iv) begin
        chk("inst_hold", inst, prev_inst);
        chk("pc_hold", pc, prev_pc);
      end
      prev_req  = imem_req;
      prev_iv   = inst_valid;
      prev_addr = imem_addr;
      prev_inst = inst;
      prev_pc   = pc;
    end
  end

  task automatic wait_req();
    int n;
    n = 0;
    while (!imem_req && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    chk("req_timeout", {31'd0, imem_req}, 32'd1);
  endtask

  task automatic do_reset(input int hold);
    resetn = 1'b0;
    commit = 1'b0;
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_iv", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_trap", {31'd0, trap}, 32'd0);
    exp_addr_q.delete();
    exp_inst_q.delete();
    trap_q.delete();
    pc_model = RESET_PC;
    exp_addr_q.push_back(RESET_PC);
    imem_ack   = 1'b1;
    imem_rdata = $urandom;
    repeat (hold) @(posedge clock);
    #1;
    imem_ack = 1'b0;
    resetn   = 1'b1;
    @(negedge clock); #1;
    chk("rst_idle_cycle", {31'd0, imem_req}, 32'd0);
  endtask

  task automatic fetch(input logic [31:0] word, input int dly);
    wait_req();
    for (int i = 0; i < dly; i++) begin
      commit = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
    end
    commit     = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = word;
    exp_inst_q.push_back('{pc: pc_model, word: word});
    @(posedge clock); #1;
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
  endtask

  task automatic execute(input logic [1:0] ps, input logic [31:0] rav,
                         input logic [31:0] npc_exp, input bit trap_exp);
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++) begin
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      @(posedge clock); #1;
    end
    imem_ack = 1'b0;
    pcsource = ps;
    ra       = rav;
    commit   = 1'b1;
    exp_addr_q.push_back(npc_exp);
    pc_model = npc_exp;
    @(posedge clock); #1;
    commit   = 1'b0;
    pcsource = 2'($urandom_range(0, 3));
    ra       = $urandom;
    if (trap_exp) trap_q.push_back(cyc + 1);
  endtask

  task automatic step(input logic [31:0] word, input int dly, input logic [1:0] ps,
                      input logic [31:0] rav, input logic [31:0] npc_exp, input bit trap_exp);
    fetch(word, dly);
    execute(ps, rav, npc_exp, trap_exp);
  endtask

  task automatic rand_step();
    logic [31:0] w;
    logic [31:0] r;
    logic [1:0]  ps;
    logic [32:0] res;
    w   = $urandom;
    r   = $urandom;
    ps  = 2'($urandom_range(0, 3));
    res = ref_next(pc_model, w, ps, r);
    step(w, $urandom_range(0, 4), ps, r, res[31:0], res[32]);
  endtask

  initial begin
    #2;
    do_reset(3);
    step(32'h2001_0005, 0, 2'b00, $urandom, 32'h0000_0004, 1'b0);
    step($urandom, 1, 2'b10, 32'h0000_0040, 32'h0000_0040, 1'b0);
    step(32'h0000_FFFE, 5, 2'b01, $urandom, 32'h0000_003C, 1'b0);
    step($urandom, 0, 2'b10, 32'h0000_0040, 32'h0000_0040, 1'b0);
    step(32'h0000_0003, 2, 2'b01, $urandom, 32'h0000_0050, 1'b0);
    step($urandom, 0, 2'b10, 32'h1000_0010, 32'h1000_0010, 1'b0);
    step(32'h0C00_0100, 1, 2'b11, $urandom, 32'h1000_0400, 1'b0);
`ifdef IF_MISALIGN_TRAP_EN
    step($urandom, 0, 2'b10, 32'h0000_0203, 32'h0000_0080, 1'b1);
`else
    step($urandom, 0, 2'b10, 32'h0000_0203, 32'h0000_0200, 1'b0);
`endif
    step($urandom, 3, 2'b10, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    step($urandom, 0, 2'b00, $urandom, 32'h0000_0000, 1'b0);
    for (int i = 0; i < 40; i++) rand_step();

    // Reset while a fetch is outstanding
    wait_req();
    repeat (2) @(posedge clock);
    #1;
    do_reset(2);
    rand_step();
    rand_step();

    // Reset while an instruction is held in S_EXEC
    fetch($urandom, 1);
    @(posedge clock); #1;
    do_reset(1);
    for (int i = 0; i < 10; i++) rand_step();

    wait_req();
    repeat (4) @(posedge clock);
    #1;
    chk("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
    chk("inst_q_drained", 32'(exp_inst_q.size()), 32'd0);
    chk("trap_q_drained", 32'(trap_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
